prll_bs_rr_arbiter: RTL and testbench

- Parametrised single-bus arbiter and generator for DRVRS drivers, each attached through an external FWFT FIFO pair.
- Successor to the fixed 2-driver bus generator. Adds:
  - round-robin fairness,
  - per-destination back-pressure (full),
  - drop/error reporting for invalid destinations,
  - a flat, packed port interface that instantiates directly from Verilog block designs.
- Routes each popped word to the driver addressed in its header, or to all other drivers on broadcast.

---
 rtl/prll_bs_pkg.sv | 31 +++
 rtl/prll_bs_rr_pick.sv | 43 ++++
 rtl/prll_bs_rr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_prll_bs_rr_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prll_bs_pkg.sv
// prll_bs_pkg: shared types and helpers for the prll_bs bus arbiter family.
//   state_t      : arbiter FSM states (IDLE, DELIVER).
//   MAX_BITS     : widest data word accepted by get_dst_id.
//   drvr_idx_w() : index width needed to address n drivers (at least 1).
//   get_dst_id() : extracts the id_w-bit destination field from the top of a word.
package prll_bs_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    DELIVER = 1'b1
  } state_t;

  localparam int unsigned MAX_BITS = 256;

  function automatic int unsigned drvr_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // word is the data word zero-extended to MAX_BITS; the ID sits in
  // bits [bits-1 -: id_w]. Supports id_w up to 32.
  function automatic logic [31:0] get_dst_id(input logic [MAX_BITS-1:0] word,
                                             input int unsigned bits,
                                             input int unsigned id_w);
    logic [MAX_BITS-1:0] sh;
    logic [31:0]         mask;
    sh   = word >> (bits - id_w);
    mask = (id_w >= 32) ? '1 : ((32'd1 << id_w) - 32'd1);
    return sh[31:0] & mask;
  endfunction

endpackage

// File: rtl/prll_bs_rr_pick.sv
// prll_bs_rr_pick: combinational cyclic priority picker.
//   req [drvrs]  : request vector.
//   ptr [idx_w]  : index that has highest priority this cycle (< drvrs).
//   gnt [drvrs]  : one-hot grant of the first request at or after ptr.
//   idx [idx_w]  : binary index of the granted request.
//   any          : at least one request is present.
module prll_bs_rr_pick
  import prll_bs_pkg::*;
#(
  parameter int unsigned drvrs = 4,
  parameter int unsigned idx_w = 2
) (
  input  logic [drvrs-1:0] req,
  input  logic [idx_w-1:0] ptr,
  output logic [drvrs-1:0] gnt,
  output logic [idx_w-1:0] idx,
  output logic             any
);

  logic [2*drvrs-1:0] dbl;
  int unsigned        sel;

  // Rotating a doubled copy right by ptr puts the highest-priority request
  // at bit 0, so a plain fixed-priority scan gives the cyclic order.
  always_comb begin
    dbl = {req, req} >> ptr;
    any = 1'b0;
    sel = 0;
    gnt = '0;
    for (int unsigned k = 0; k < drvrs; k++) begin
      if (!any && dbl[k]) begin
        any = 1'b1;
        sel = 32'(ptr) + k;
        if (sel >= drvrs) sel = sel - drvrs;
      end
    end
    for (int unsigned j = 0; j < drvrs; j++) begin
      gnt[j] = any && (sel == j);
    end
    idx = idx_w'(sel);
  end

endmodule

// File: rtl/prll_bs_rr_arbiter.sv
// prll_bs_rr_arbiter: single-bus round-robin arbiter for drvrs drivers, each
// attached through an external FWFT FIFO pair.
//   clk, reset : rising-edge clock, synchronous active-high reset.
//   pndng/pop  : source FIFO non-empty flags / one-hot pop strobes.
//   D_pop      : packed source words, slice i = [i*bits +: bits].
//   full/push  : destination FIFO full flags / push strobes (multi-hot on broadcast).
//   D_push     : packed bus word, every slice identical.
//   drop       : one-cycle pulse when a word with an invalid destination is discarded.
//   busy       : a word is held on the bus waiting for delivery.
// Optional macro PRLL_BS_STATS_EN adds saturating counters xfer_cnt [31:0]
// (completed deliveries) and drop_cnt [15:0] (drop pulses).
module prll_bs_rr_arbiter
  import prll_bs_pkg::*;
#(
  parameter int unsigned     bits      = 32,
  parameter int unsigned     drvrs     = 4,
  parameter int unsigned     id_w      = 8,
  parameter logic [id_w-1:0] broadcast = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [drvrs-1:0]      pndng,
  output logic [drvrs-1:0]      pop,
  input  logic [drvrs*bits-1:0] D_pop,
  input  logic [drvrs-1:0]      full,
  output logic [drvrs-1:0]      push,
  output logic [drvrs*bits-1:0] D_push,
  output logic                  drop,
  output logic                  busy
`ifdef PRLL_BS_STATS_EN
  ,
  output logic [31:0]           xfer_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int unsigned IDX_W = drvr_idx_w(drvrs);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [bits-1:0]    bus_reg_q, bus_reg_d;
  logic [IDX_W-1:0]   src_reg_q, src_reg_d;
  logic [drvrs-1:0]   dst_mask_q, dst_mask_d;
  logic               drop_q, drop_d;

  logic [drvrs-1:0]   pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [bits-1:0]    win_word;
  logic [id_w-1:0]    dst_id;
  logic [drvrs-1:0]   dst_onehot;
  logic               dst_valid;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    return (32'(i) == drvrs - 1) ? '0 : i + IDX_W'(1);
  endfunction

  prll_bs_rr_pick #(
    .drvrs (drvrs),
    .idx_w (IDX_W)
  ) u_pick (
    .req (pndng),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Winner's word and destination decode.
  always_comb begin
    win_word = '0;
    for (int unsigned k = 0; k < drvrs; k++) begin
      if (pick_gnt[k]) win_word = D_pop[k*bits +: bits];
    end
    dst_id     = id_w'(get_dst_id(MAX_BITS'(win_word), bits, id_w));
    dst_onehot = '0;
    for (int unsigned k = 0; k < drvrs; k++) begin
      dst_onehot[k] = (32'(dst_id) == k);
    end
    dst_valid = (32'(dst_id) < drvrs) && (32'(dst_id) != 32'(pick_idx));
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    bus_reg_d  = bus_reg_q;
    src_reg_d  = src_reg_q;
    dst_mask_d = dst_mask_q;
    drop_d     = 1'b0;
    pop        = '0;
    push       = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          pop       = pick_gnt;
          bus_reg_d = win_word;
          src_reg_d = pick_idx;
          if (dst_id == broadcast) begin
            dst_mask_d = ~pick_gnt;
            state_d    = DELIVER;
          end else if (dst_valid) begin
            dst_mask_d = dst_onehot;
            state_d    = DELIVER;
          end else begin
            dst_mask_d = '0;
            drop_d     = 1'b1;
            rr_ptr_d   = inc_idx(pick_idx);
          end
        end
      end
      DELIVER: begin
        // Broadcast waits until every destination has room at once.
        if ((full & dst_mask_q) == '0) begin
          push     = dst_mask_q;
          rr_ptr_d = inc_idx(src_reg_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobes are suppressed during reset so a held word is never delivered.
    if (reset) begin
      pop  = '0;
      push = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      bus_reg_q  <= '0;
      src_reg_q  <= '0;
      dst_mask_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      bus_reg_q  <= bus_reg_d;
      src_reg_q  <= src_reg_d;
      dst_mask_q <= dst_mask_d;
      drop_q     <= drop_d;
    end
  end

  assign D_push = {drvrs{bus_reg_q}};
  assign drop   = drop_q;
  assign busy   = (state_q == DELIVER);

`ifdef PRLL_BS_STATS_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        deliver_done;

  always_comb begin
    deliver_done = (state_q == DELIVER) && ((full & dst_mask_q) == '0);
    xfer_cnt_d   = xfer_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (deliver_done && (xfer_cnt_q != '1)) xfer_cnt_d = xfer_cnt_q + 32'd1;
    if (drop_d && (drop_cnt_q != '1))       drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_prll_bs_rr_arbiter.sv
module tb_prll_bs_rr_arbiter;

  localparam int unsigned BITS  = 32;
  localparam int unsigned DRVRS = 4;

  logic                  clk;
  logic                  reset;
  logic [DRVRS-1:0]      pndng;
  logic [DRVRS-1:0]      pop;
  logic [DRVRS*BITS-1:0] d_pop;
  logic [DRVRS-1:0]      full;
  logic [DRVRS-1:0]      push;
  logic [DRVRS*BITS-1:0] d_push;
  logic                  drop;
  logic                  busy;
`ifdef PRLL_BS_STATS_EN
  logic [31:0]           xfer_cnt;
  logic [15:0]           drop_cnt;
`endif

  prll_bs_rr_arbiter #(
    .bits  (BITS),
    .drvrs (DRVRS),
    .id_w  (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .pop    (pop),
    .D_pop  (d_pop),
    .full   (full),
    .push   (push),
    .D_push (d_push),
    .drop   (drop),
    .busy   (busy)
`ifdef PRLL_BS_STATS_EN
    ,
    .xfer_cnt (xfer_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  push;
    logic        drop;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int unsigned src;
    logic [31:0] word;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic        drop;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every push or drop the DUT produces must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset && (push != '0 || drop)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got push=%b drop=%b expected no event at %0t",
                 push, drop, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("push_mask", 32'(push), 32'(mon_e.push));
        chk("drop_flag", 32'(drop), 32'(mon_e.drop));
        if (!mon_e.drop) begin
          for (int i = 0; i < DRVRS; i++) begin
            chk("d_push_slice", d_push[i*BITS +: BITS], mon_e.data);
          end
        end
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    pndng = '0;
    full  = '0;
    d_pop = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns the same way.
  task automatic run_vec(input vec_t v);
    exp_t e;
    pndng = 4'(1 << v.src);
    d_pop = '0;
    d_pop[v.src*BITS +: BITS] = v.word;
    e.push = v.push;
    e.drop = v.drop;
    e.data = v.word;
    sb.push_back(e);
    @(negedge clk);
    chk("vec_pop", 32'(pop), 32'(v.pop));
    chk("vec_busy_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    pndng = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 32'h0200ABCD, 4'b0001, 4'b0100, 1'b0};
    vecs[1] = '{1, 32'hFF123456, 4'b0010, 4'b1101, 1'b0};
    vecs[2] = '{2, 32'h07000000, 4'b0100, 4'b0000, 1'b1};
    vecs[3] = '{3, 32'h03000001, 4'b1000, 4'b0000, 1'b1};
    vecs[4] = '{3, 32'h00000055, 4'b1000, 4'b0001, 1'b0};
    vecs[5] = '{0, 32'h00000000, 4'b0001, 4'b0000, 1'b1};
    vecs[6] = '{2, 32'h01FFFFFF, 4'b0100, 4'b0010, 1'b0};
    vecs[7] = '{0, 32'hFF000000, 4'b0001, 4'b1110, 1'b0};
    vecs[8] = '{3, 32'h04000000, 4'b1000, 4'b0000, 1'b1};
    vecs[9] = '{2, 32'hFE000000, 4'b0100, 4'b0000, 1'b1};

    apply_reset();
    @(negedge clk);
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_d_push", d_push[31:0], 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Round-robin: all four pending from rr_ptr=0 -> grants 0,1,2,3,0.
    apply_reset();
    begin
      int unsigned order[5] = '{0, 1, 2, 3, 0};
      exp_t e;
      d_pop = {32'h00000033, 32'h00000022, 32'h00000011, 32'h01000000};
      pndng = 4'b1111;
      for (int g = 0; g < 5; g++) begin
        e.push = (order[g] == 0) ? 4'b0010 : 4'b0001;
        e.drop = 1'b0;
        e.data = d_pop[order[g]*BITS +: BITS];
        sb.push_back(e);
        @(negedge clk);
        chk("rr_grant", 32'(pop), 32'(1 << order[g]));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rr_no_pop_deliver", 32'(pop), 32'd0);
        @(posedge clk);
        #1;
      end
      pndng = '0;
    end

    // Back-pressure: unicast 0->3 held off by full[3] for 5 cycles.
    begin
      exp_t e;
      full  = 4'b1000;
      pndng = 4'b0001;
      d_pop = '0;
      d_pop[31:0] = 32'h03000000;
      e.push = 4'b1000;
      e.drop = 1'b0;
      e.data = 32'h03000000;
      sb.push_back(e);
      @(negedge clk);
      chk("bp_pop", 32'(pop), 32'b0001);
      @(posedge clk);
      #1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_push_held", 32'(push), 32'd0);
        chk("bp_no_pop", 32'(pop), 32'd0);
        @(posedge clk);
        #1;
      end
      full  = '0;
      pndng = '0;
      @(negedge clk);
      chk("bp_release_push", 32'(push), 32'b1000);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_idle", 32'(busy), 32'd0);
      chk("d_push_holds", d_push[31:0], 32'h03000000);
      @(posedge clk);
      #1;
    end

    // Reset while a word is held on the bus.
    full  = 4'b0010;
    pndng = 4'b0001;
    d_pop = '0;
    d_pop[31:0] = 32'h01000077;
    @(negedge clk);
    chk("rd_pop", 32'(pop), 32'b0001);
    @(posedge clk);
    #1;
    pndng = '0;
    @(negedge clk);
    chk("rd_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    full  = '0;
    @(negedge clk);
    chk("rd_pop0", 32'(pop), 32'd0);
    chk("rd_push0", 32'(push), 32'd0);
    chk("rd_d_push0", d_push[63:32], 32'd0);
    chk("rd_drop0", 32'(drop), 32'd0);
    chk("rd_busy0", 32'(busy), 32'd0);
`ifdef PRLL_BS_STATS_EN
    chk("rd_xfer_cnt", xfer_cnt, 32'd0);
    chk("rd_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    // rr_ptr must be back at 0: with everyone pending, driver 0 wins.
    begin
      exp_t e;
      pndng = 4'b1111;
      d_pop = {32'h00000003, 32'h00000002, 32'h00000001, 32'h02000099};
      e.push = 4'b0100;
      e.drop = 1'b0;
      e.data = 32'h02000099;
      sb.push_back(e);
      @(negedge clk);
      chk("rd_rr_ptr0", 32'(pop), 32'b0001);
      @(posedge clk);
      #1;
      pndng = '0;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
